// File: rtl/tone_pkg.sv
// Shared types and keypad note table for the tone sequencer.
// Frequencies are integer Hz fed straight to the tone generator.
package tone_pkg;

  localparam int FREQ_W = 32;

  localparam logic [3:0] KEY_REST_LO = 4'd10;
  localparam logic [3:0] KEY_REST_HI = 4'd13;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    GAP
  } state_e;

  function automatic logic [FREQ_W-1:0] key_freq(
    input logic [3:0] code
  );
    logic [FREQ_W-1:0] f;
    f = '0;
    if (code >= KEY_REST_LO && code <= KEY_REST_HI) begin
      f = '0;
    end else begin
      case (code)
        4'd0:    f = 32'd466;
        4'd1:    f = 32'd261;
        4'd2:    f = 32'd277;
        4'd3:    f = 32'd294;
        4'd4:    f = 32'd311;
        4'd5:    f = 32'd330;
        4'd6:    f = 32'd349;
        4'd7:    f = 32'd370;
        4'd8:    f = 32'd392;
        4'd9:    f = 32'd415;
        4'd14:   f = 32'd440;
        4'd15:   f = 32'd494;
        default: f = '0;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter shared by note and gap timing.
// zero is registered and always matches the held count.
module note_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q, zero_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
    zero_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/tone_sequencer.sv
// Drives the tone generator from the keypad or from song ROM playback.
// Song entries are fetched, held for len ticks, then followed by a gap.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 10_000_000,
  parameter int unsigned GAP_CYCLES  = 500_000,
  parameter int          ADDR_W      = 9,
  parameter int          LEN_W       = 3,
  parameter int unsigned SONG0_BASE  = 0,
  parameter int unsigned SONG1_BASE  = 16
) (
  input  logic              FPGA_CLK1_50,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [3:0]        key_num,
  input  logic              play_song,
  input  logic              song_sel,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_freq,
  input  logic [LEN_W-1:0]  rom_len,
  input  logic              rom_last,
  output logic [31:0]       desiredFrequency,
  output logic              busy,
  output logic              note_strobe
);

  localparam longint unsigned MAX_PLAY =
    longint'((2 ** LEN_W) - 1) * longint'(TICK_CYCLES);
  localparam longint unsigned MAX_CNT =
    (MAX_PLAY > longint'(GAP_CYCLES)) ? MAX_PLAY : longint'(GAP_CYCLES);
  localparam int CNT_W = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] TICK_V = CNT_W'(TICK_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                busy_q, busy_d;
  logic                strobe_q, strobe_d;
  logic                last_q, last_d;

  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_en;
  logic                tmr_zero;
  logic [CNT_W-1:0]    play_ld;
  logic                exit_go;

  // Full-width product so the longest note never truncates.
  assign play_ld = CNT_W'(rom_len) * TICK_V - CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    freq_d   = freq_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    last_d   = last_q;
    tmr_load = 1'b0;
    tmr_val  = play_ld;
    tmr_en   = 1'b0;
    exit_go  = 1'b0;

    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      freq_d  = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (play_song && !stop) begin
            addr_d  = song_sel ? ADDR_W'(SONG1_BASE)
                               : ADDR_W'(SONG0_BASE);
            busy_d  = 1'b1;
            freq_d  = '0;
            state_d = FETCH;
          end else begin
            freq_d = key_valid ? key_freq(key_num) : '0;
          end
        end
        FETCH: begin
          state_d = LOAD;
        end
        LOAD: begin
          // Top address acts as end of song; never wrap to 0.
          last_d = rom_last || (addr_q == '1);
          if (rom_len == '0) begin
            if (last_d) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              freq_d  = '0;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = FETCH;
            end
          end else begin
            freq_d   = rom_freq;
            strobe_d = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = play_ld;
            state_d  = PLAY;
          end
        end
        PLAY: begin
          tmr_en = 1'b1;
          if (tmr_zero) begin
            freq_d = '0;
            if (GAP_CYCLES > 0) begin
              tmr_load = 1'b1;
              tmr_val  = GAP_LD;
              state_d  = GAP;
            end else begin
              exit_go = 1'b1;
            end
          end
        end
        GAP: begin
          tmr_en = 1'b1;
          if (tmr_zero) begin
            exit_go = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (exit_go) begin
        if (last_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          freq_d  = '0;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end
    end
  end

  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      freq_q   <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      freq_q   <= freq_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
    end
  end

  note_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk       (FPGA_CLK1_50),
    .reset     (reset),
    .load      (tmr_load),
    .load_value(tmr_val),
    .en        (tmr_en),
    .zero      (tmr_zero)
  );

  assign rom_addr         = addr_q;
  assign desiredFrequency = freq_q;
  assign busy             = busy_q;
  assign note_strobe      = strobe_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a behavioural 1-cycle song ROM.
// TICK_CYCLES=4, GAP_CYCLES=2.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_num;
  logic        play_song;
  logic        song_sel;
  logic        stop;
  logic [8:0]  rom_addr;
  logic [31:0] rom_freq;
  logic [2:0]  rom_len;
  logic        rom_last;
  logic [31:0] desiredFrequency;
  logic        busy;
  logic        note_strobe;

  logic [31:0] mf [0:511];
  logic [2:0]  ml [0:511];
  logic        mlast [0:511];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_freq <= mf[rom_addr];
    rom_len  <= ml[rom_addr];
    rom_last <= mlast[rom_addr];
  end

  tone_sequencer #(
    .TICK_CYCLES(4),
    .GAP_CYCLES (2),
    .ADDR_W     (9),
    .LEN_W      (3),
    .SONG0_BASE (0),
    .SONG1_BASE (16)
  ) dut (
    .FPGA_CLK1_50    (clk),
    .reset           (reset),
    .key_valid       (key_valid),
    .key_num         (key_num),
    .play_song       (play_song),
    .song_sel        (song_sel),
    .stop            (stop),
    .rom_addr        (rom_addr),
    .rom_freq        (rom_freq),
    .rom_len         (rom_len),
    .rom_last        (rom_last),
    .desiredFrequency(desiredFrequency),
    .busy            (busy),
    .note_strobe     (note_strobe)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int strobes;
    bit seen;
    logic [31:0] ef;
    logic [31:0] es;
    logic [31:0] eb;

    for (int i = 0; i < 512; i++) begin
      mf[i] = '0;
      ml[i] = '0;
      mlast[i] = 1'b0;
    end
    mf[0] = 32'd392; ml[0] = 3'd1;
    mf[1] = 32'd0;   ml[1] = 3'd2;
    mf[2] = 32'd440; ml[2] = 3'd1; mlast[2] = 1'b1;
    mf[16] = 32'd500; ml[16] = 3'd0;
    mf[17] = 32'd330; ml[17] = 3'd1; mlast[17] = 1'b1;

    reset = 1'b1; key_valid = 1'b0; key_num = 4'd0;
    play_song = 1'b0; song_sel = 1'b0; stop = 1'b0;
    step();
    step();
    chk("rst_freq", desiredFrequency, 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(note_strobe), 32'd0);
    reset = 1'b0;

    // keypad in IDLE
    key_valid = 1'b1; key_num = 4'd14;
    step();
    chk("key14", desiredFrequency, 32'd440);
    key_num = 4'd11;
    step();
    chk("key11", desiredFrequency, 32'd0);
    key_num = 4'd0;
    step();
    chk("key0", desiredFrequency, 32'd466);
    key_valid = 1'b0;
    step();
    chk("key_off", desiredFrequency, 32'd0);

    // full song 0
    play_song = 1'b1; song_sel = 1'b0;
    strobes = 0;
    for (int k = 1; k <= 29; k++) begin
      step();
      play_song = 1'b0;
      if (k == 1) chk("s0_addr_t1", 32'(rom_addr), 32'd0);
      ef = (k >= 3 && k <= 6)   ? 32'd392 :
           (k >= 23 && k <= 26) ? 32'd440 : 32'd0;
      es = (k == 3 || k == 11 || k == 23) ? 32'd1 : 32'd0;
      eb = (k <= 28) ? 32'd1 : 32'd0;
      chk($sformatf("s0_freq_k%0d", k), desiredFrequency, ef);
      chk($sformatf("s0_strobe_k%0d", k), 32'(note_strobe), es);
      chk($sformatf("s0_busy_k%0d", k), 32'(busy), eb);
      if (note_strobe) strobes++;
    end
    chk("s0_strobe_count", 32'(strobes), 32'd3);

    // stop during the 440 note
    play_song = 1'b1; song_sel = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      play_song = 1'b0;
    end
    chk("pre_stop_freq", desiredFrequency, 32'd440);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_freq", desiredFrequency, 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_addr", 32'(rom_addr), 32'd2);
    step();
    chk("stop_idle_busy", 32'(busy), 32'd0);

    // restart, then ignored play_song mid-song
    play_song = 1'b1; song_sel = 1'b0;
    step();
    play_song = 1'b0;
    chk("restart_addr", 32'(rom_addr), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    for (int k = 2; k <= 12; k++) step();
    chk("mid_addr", 32'(rom_addr), 32'd1);
    play_song = 1'b1; song_sel = 1'b1;
    step();
    play_song = 1'b0;
    chk("replay_addr", 32'(rom_addr), 32'd1);
    chk("replay_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop2_busy", 32'(busy), 32'd0);

    // play and stop together from IDLE
    play_song = 1'b1; stop = 1'b1; song_sel = 1'b0;
    step();
    play_song = 1'b0; stop = 1'b0;
    chk("ps_busy", 32'(busy), 32'd0);
    chk("ps_addr", 32'(rom_addr), 32'd1);
    step();
    chk("ps_busy2", 32'(busy), 32'd0);

    // song 1: skipped len-0 entry then last note
    play_song = 1'b1; song_sel = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      play_song = 1'b0;
      if (k == 1) chk("s1_addr_t1", 32'(rom_addr), 32'd16);
      if (k == 3) chk("s1_addr_t3", 32'(rom_addr), 32'd17);
      ef = (k >= 5 && k <= 8) ? 32'd330 : 32'd0;
      es = (k == 5) ? 32'd1 : 32'd0;
      eb = (k <= 10) ? 32'd1 : 32'd0;
      chk($sformatf("s1_freq_k%0d", k), desiredFrequency, ef);
      chk($sformatf("s1_strobe_k%0d", k), 32'(note_strobe), es);
      chk($sformatf("s1_busy_k%0d", k), 32'(busy), eb);
    end

    // run off the top of the ROM
    for (int i = 16; i < 511; i++) begin
      mf[i] = 32'd500; ml[i] = 3'd0; mlast[i] = 1'b0;
    end
    mf[511] = 32'd523; ml[511] = 3'd1; mlast[511] = 1'b0;
    play_song = 1'b1; song_sel = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      step();
      play_song = 1'b0;
      if (note_strobe) seen = 1'b1;
    end
    chk("wrap_seen", 32'(seen), 32'd1);
    chk("wrap_addr", 32'(rom_addr), 32'd511);
    chk("wrap_freq", desiredFrequency, 32'd523);
    step(); step(); step();
    chk("wrap_freq_end", desiredFrequency, 32'd523);
    step();
    chk("wrap_gap_freq", desiredFrequency, 32'd0);
    chk("wrap_gap_busy", 32'(busy), 32'd1);
    step();
    chk("wrap_gap_busy2", 32'(busy), 32'd1);
    step();
    chk("wrap_done_busy", 32'(busy), 32'd0);
    step(); step(); step();
    chk("wrap_no_wrap", 32'(rom_addr), 32'd511);
    chk("wrap_idle", 32'(busy), 32'd0);

    // keypad held during playback
    key_valid = 1'b1; key_num = 4'd1;
    play_song = 1'b1; song_sel = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      step();
      play_song = 1'b0;
      if (k == 3)  chk("kh_note", desiredFrequency, 32'd392);
      if (k == 20) chk("kh_rest", desiredFrequency, 32'd0);
      if (k == 28) chk("kh_gap", desiredFrequency, 32'd0);
    end
    chk("kh_busy_fall", 32'(busy), 32'd0);
    chk("kh_fall_freq", desiredFrequency, 32'd0);
    step();
    chk("kh_resume", desiredFrequency, 32'd261);

    // reset during PLAY
    play_song = 1'b1; song_sel = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      play_song = 1'b0;
    end
    chk("pre_rst_freq", desiredFrequency, 32'd392);
    reset = 1'b1;
    step();
    chk("mrst_freq", desiredFrequency, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_addr", 32'(rom_addr), 32'd0);
    chk("mrst_strobe", 32'(note_strobe), 32'd0);
    reset = 1'b0; key_valid = 1'b0;
    for (int k = 0; k < 12; k++) step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_addr", 32'(rom_addr), 32'd0);
    chk("post_rst_freq", desiredFrequency, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Controller that owns the speaker tone datapath's frequency input. It arbitrates between live keypad notes and autonomous song playback.
- Songs are fetched from an external synchronous song ROM.
- Each note is held for a duration counted in tick units, then followed by a short articulation gap.
- desiredFrequency drives the existing tone generator directly.

Parameters:
TICK_CYCLES, 10_000_000, clock cycles per duration unit (200 ms at 50 MHz)
GAP_CYCLES, 500_000, silent cycles inserted after every played note; 0 disables the gap
ADDR_W, 9, song ROM address width
LEN_W, 3, duration field width in units
SONG0_BASE, 0, ROM start address of song 0 (random tune)
SONG1_BASE, 16, ROM start address of song 1 (sea shanty)

Ports:
FPGA_CLK1_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
key_valid  in  1  keypad key currently pressed
key_num  in  4  keypad code
play_song  in  1  single-cycle start request
song_sel  in  1  song to play: 0 = SONG0_BASE, 1 = SONG1_BASE; sampled with play_song
stop  in  1  single-cycle abort
rom_addr  out  ADDR_W  song ROM address
rom_freq  in  32  ROM data: frequency in Hz; 0 = rest
rom_len  in  LEN_W  ROM data: duration in units; 0 = skip entry
rom_last  in  1  ROM data: final entry of song
desiredFrequency  out  32  tone generator frequency in Hz; 0 = silent
busy  out  1  song playback in progress
note_strobe  out  1  one-cycle pulse each time a ROM note is loaded

Behaviour:
- Reset (synchronous, active-high): state IDLE; desiredFrequency=0, rom_addr=0, busy=0, note_strobe=0; counter cleared. Reset mid-song aborts playback with no further ROM reads.
- All outputs are registered.
- ROM read latency is 1 cycle: data for the address presented in cycle n is valid in cycle n+1.
- IDLE (busy=0):
  - Each cycle: desiredFrequency <= key_freq(key_num) when key_valid, else 0.
  - Key map: 0→466, 1→261, 2→277, 3→294, 4→311, 5→330, 6→349, 7→370, 8→392, 9→415, 14→440, 15→494; 10–13→0.
  - play_song: rom_addr <= selected base, busy <= 1, desiredFrequency <= 0, go to FETCH.
- FETCH: 1 wait cycle for the ROM, then go to LOAD.
- LOAD: capture rom_freq, rom_len, rom_last.
  - rom_len==0: skip the entry. If last, go to IDLE; else rom_addr+1, go to FETCH. No strobe.
  - Otherwise: desiredFrequency <= rom_freq, note_strobe <= 1 (one cycle), counter <= rom_len*TICK_CYCLES-1, go to PLAY.
- PLAY: decrement the counter. At 0:
  - GAP_CYCLES>0: desiredFrequency <= 0, counter <= GAP_CYCLES-1, go to GAP.
  - GAP_CYCLES==0: perform the GAP exit directly.
- GAP: decrement the counter. At 0 (exit):
  - If last, go to IDLE: busy <= 0, desiredFrequency <= 0.
  - Else rom_addr+1, go to FETCH.
- Timing from play_song sampled in cycle t:
  - rom_addr valid at t+1.
  - LOAD at t+2.
  - desiredFrequency and note_strobe valid at t+3.
  - A note occupies exactly len*TICK_CYCLES cycles at rom_freq, then GAP_CYCLES cycles at 0.
- Counter width must hold (2^LEN_W-1)*TICK_CYCLES; the multiply is computed at full width with no truncation.
- Address wrap: if rom_addr==2^ADDR_W-1 and the entry is not last, treat it as last; the address never wraps to 0.
- Simultaneous events:
  - stop outranks play_song.
  - stop in any non-IDLE state: go to IDLE next cycle with desiredFrequency=0 and busy=0.
  - stop in IDLE has no effect.
  - play_song while busy is ignored.
  - Keypad input is ignored while busy; when busy drops, key handling resumes on the next cycle.
- A rest entry (rom_freq=0, len>0) plays silence for the full duration, still strobes, and still gets its gap.

Decomposition:
- Package tone_pkg holds:
  - state enum (IDLE, FETCH, LOAD, PLAY, GAP)
  - FREQ_W=32 constant
  - key_freq function (4-bit code → frequency)
  - key-code constants KEY_REST_LO=10, KEY_REST_HI=13
- One sub-module, note_timer: loadable down-counter with load, load_value, en, and a registered zero flag; used for both PLAY and GAP.
- The song ROM stays external.

Test Plan (TICK_CYCLES=4, GAP_CYCLES=2, song 0 ROM = {392,len1}, {0,len2}, {440,len1,last}):
1. IDLE, key_valid=1, key_num=14 → desiredFrequency=440 one cycle later. key_num=11 → 0. key_valid=0 → 0.
2. play_song, song_sel=0 at t → rom_addr=0 at t+1; desiredFrequency=392 and note_strobe=1 at t+3. Sequence: 392 for 4 cycles, 0 for 2, 0 for 8 (rest), 0 for 2, 440 for 4, 0 for 2. Then busy=0, with exactly 3 strobes.
3. stop asserted during the 440 note → desiredFrequency=0 and busy=0 next cycle; rom_addr unchanged; later play_song restarts from address 0.
4. play_song and stop in the same cycle from IDLE → stays IDLE. A second play_song mid-song does not reset rom_addr.
5. ROM entry {500,len0} before the last entry → no strobe, no 500 output, next address fetched. Entry at address 511 without last → playback ends after its gap.
6. reset asserted during PLAY → all outputs 0 next cycle. key_valid=1, key_num=1 held during playback → ignored; 261 appears the cycle after busy falls.
